// File: rtl/countdown_display_if.sv
// Sample request, snapshot inputs and BCD readout between the interval counter and the display.
interface countdown_display_if #(
  parameter int INT_W = 16,
  parameter int CNT_W = 21
);
  logic             start;
  logic [CNT_W-1:0] count_in;
  logic [INT_W-1:0] interval;
  logic             warn;
  logic             busy;
  logic             done;
  logic [19:0]      min_bcd;
  logic [7:0]       sec_bcd;
  logic             blank;

  modport master (
    output start, count_in, interval, warn,
    input  busy, done, min_bcd, sec_bcd, blank
  );

  modport slave (
    input  start, count_in, interval, warn,
    output busy, done, min_bcd, sec_bcd, blank
  );
endinterface

// File: rtl/countdown_display.sv
// Remaining-time MM:SS readout: (interval*60 - count) / 60, both fields to packed BCD.
// Done pulses 2+REM_W+INT_W cycles after an accepted start; starts while busy are dropped.
module countdown_display #(
  parameter int INT_W = 16,
  parameter int CNT_W = 21
) (
  input  logic                clock,
  input  logic                reset,
  countdown_display_if.slave  bus
);
  localparam int REM_W  = CNT_W + 1;
  localparam int STEP_W = $clog2(REM_W + 1);

  typedef enum logic [2:0] {IDLE, SUB, DIV, BCD, OUT} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  snap_cnt;
  logic [INT_W-1:0]  snap_int;
  logic              snap_warn;
  logic [REM_W-1:0]  dvd;
  logic [5:0]        prem;
  logic [STEP_W-1:0] step;
  logic [19:0]       min_sh;
  logic [7:0]        sec_sh;
  logic [19:0]       min_bcd_q;
  logic [7:0]        sec_bcd_q;
  logic              blank_q;
  logic              done_q;
  logic              busy_c;

  logic [REM_W-1:0]  tgt;
  logic [REM_W-1:0]  cnt_ext;
  logic [REM_W-1:0]  remaining;
  logic [6:0]        trial;
  logic [6:0]        trial_sub;
  logic              q_bit;
  logic [19:0]       min_adj;
  logic [7:0]        sec_adj;
  logic              div_last;
  logic              bcd_last;

  function automatic logic [19:0] dab5(input logic [19:0] v);
    logic [19:0] r;
    r = v;
    for (int i = 0; i < 5; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [7:0] dab2(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < 2; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  always_comb begin
    tgt       = REM_W'(snap_int) * REM_W'(60);
    cnt_ext   = REM_W'(snap_cnt);
    remaining = (cnt_ext >= tgt) ? '0 : tgt - cnt_ext;
    // Partial remainder stays below 60, so doubling plus one bit fits in 7 bits.
    trial     = {prem, dvd[REM_W-1]};
    q_bit     = (trial >= 7'd60);
    trial_sub = trial - 7'd60;
    min_adj   = dab5(min_sh);
    sec_adj   = dab2(sec_sh);
    div_last  = (step == STEP_W'(REM_W - 1));
    bcd_last  = (step == STEP_W'(INT_W - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SUB;
      SUB:     state_nxt = DIV;
      DIV:     if (div_last) state_nxt = BCD;
      BCD:     if (bcd_last) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_cnt  <= '0;
      snap_int  <= '0;
      snap_warn <= 1'b0;
      dvd       <= '0;
      prem      <= '0;
      step      <= '0;
      min_sh    <= '0;
      sec_sh    <= '0;
      min_bcd_q <= '0;
      sec_bcd_q <= '0;
      blank_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state == OUT);
      case (state)
        IDLE: begin
          if (bus.start) begin
            snap_cnt  <= bus.count_in;
            snap_int  <= bus.interval;
            snap_warn <= bus.warn;
          end
        end
        SUB: begin
          dvd    <= remaining;
          prem   <= '0;
          step   <= '0;
          min_sh <= '0;
          sec_sh <= '0;
        end
        DIV: begin
          // Dividend shifts out MSB first while quotient bits fill in from the bottom.
          dvd  <= {dvd[REM_W-2:0], q_bit};
          prem <= q_bit ? trial_sub[5:0] : trial[5:0];
          step <= div_last ? '0 : step + 1'b1;
        end
        BCD: begin
          min_sh <= {min_adj[18:0], dvd[INT_W-1]};
          dvd    <= {dvd[REM_W-2:0], 1'b0};
          if (step < STEP_W'(6)) begin
            sec_sh <= {sec_adj[6:0], prem[5]};
            prem   <= {prem[4:0], 1'b0};
          end
          step <= step + 1'b1;
        end
        OUT: begin
          min_bcd_q <= min_sh;
          sec_bcd_q <= sec_sh;
          blank_q   <= snap_warn ? ~blank_q : 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy_c;
  assign bus.done    = done_q;
  assign bus.min_bcd = min_bcd_q;
  assign bus.sec_bcd = sec_bcd_q;
  assign bus.blank   = blank_q;
endmodule

// File: tb/tb_countdown_display.sv
// Directed vectors for the remaining-time converter: latency, clamps, dropped starts, blink, abort.
module tb_countdown_display;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  countdown_display_if #(.INT_W(16), .CNT_W(21)) bus ();

  countdown_display #(.INT_W(16), .CNT_W(21)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] interval;
    logic [20:0] count;
    logic        warn;
    logic        extra;
    logic [19:0] exp_min;
    logic [7:0]  exp_sec;
    logic        exp_blank;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          first;
    int          ndone;
    logic [19:0] got_min;
    logic [7:0]  got_sec;
    logic        got_blank;
    first = 0; ndone = 0; got_min = '0; got_sec = '0; got_blank = 1'b0;
    bus.interval = v.interval;
    bus.count_in = v.count;
    bus.warn     = v.warn;
    bus.start    = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    check($sformatf("busy_after_start[%0d]", idx), 32'(bus.busy), 32'd1);
    // Scramble live inputs; the snapshot must carry the conversion.
    bus.interval = 16'($urandom);
    bus.count_in = 21'($urandom);
    bus.warn     = ~v.warn;
    for (int k = 1; k <= 45; k++) begin
      if (v.extra && (k == 5 || k == 20)) bus.start = 1'b1;
      @(posedge clock); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (first == 0) begin
          first     = k;
          got_min   = bus.min_bcd;
          got_sec   = bus.sec_bcd;
          got_blank = bus.blank;
          check($sformatf("busy_at_done[%0d]", idx), 32'(bus.busy), 32'd0);
        end
      end
    end
    check($sformatf("done_edge[%0d]", idx), 32'(first), 32'd40);
    check($sformatf("done_count[%0d]", idx), 32'(ndone), 32'd1);
    check($sformatf("min_bcd[%0d]", idx), 32'(got_min), 32'(v.exp_min));
    check($sformatf("sec_bcd[%0d]", idx), 32'(got_sec), 32'(v.exp_sec));
    check($sformatf("blank[%0d]", idx), 32'(got_blank), 32'(v.exp_blank));
    check($sformatf("min_hold[%0d]", idx), 32'(bus.min_bcd), 32'(v.exp_min));
  endtask

  initial begin
    int ndone;
    checks = 0;
    errors = 0;
    //          interval count    warn extra exp_min      exp_sec blank
    vecs[0]  = '{16'd10,    21'd0,     1'b0, 1'b0, 20'h00010, 8'h00, 1'b0};
    vecs[1]  = '{16'd10,    21'd125,   1'b0, 1'b0, 20'h00007, 8'h55, 1'b0};
    vecs[2]  = '{16'd65535, 21'd0,     1'b0, 1'b0, 20'h65535, 8'h00, 1'b0};
    vecs[3]  = '{16'd65535, 21'd1,     1'b0, 1'b0, 20'h65534, 8'h59, 1'b0};
    vecs[4]  = '{16'd10,    21'd600,   1'b0, 1'b0, 20'h00000, 8'h00, 1'b0};
    vecs[5]  = '{16'd0,     21'd5,     1'b0, 1'b0, 20'h00000, 8'h00, 1'b0};
    vecs[6]  = '{16'd3,     21'd59,    1'b0, 1'b1, 20'h00002, 8'h01, 1'b0};
    vecs[7]  = '{16'd1000,  21'd12345, 1'b0, 1'b0, 20'h00794, 8'h15, 1'b0};
    vecs[8]  = '{16'd5,     21'd30,    1'b1, 1'b0, 20'h00004, 8'h30, 1'b1};
    vecs[9]  = '{16'd5,     21'd31,    1'b1, 1'b1, 20'h00004, 8'h29, 1'b0};
    vecs[10] = '{16'd2,     21'd0,     1'b1, 1'b0, 20'h00002, 8'h00, 1'b1};
    vecs[11] = '{16'd2,     21'd1,     1'b0, 1'b0, 20'h00001, 8'h59, 1'b0};

    bus.start = 1'b0; bus.count_in = '0; bus.interval = '0; bus.warn = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clock); #1;
      if (bus.done) ndone++;
    end
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_done_count", 32'(ndone), 32'd0);
    check("idle_min", 32'(bus.min_bcd), 32'd0);
    check("idle_sec", 32'(bus.sec_bcd), 32'd0);
    check("idle_blank", 32'(bus.blank), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Abort mid-conversion: outputs were nonzero from the last vector.
    bus.interval = 16'd10; bus.count_in = 21'd125; bus.warn = 1'b1; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_min", 32'(bus.min_bcd), 32'd0);
    check("abort_sec", 32'(bus.sec_bcd), 32'd0);
    check("abort_blank", 32'(bus.blank), 32'd0);
    // Start presented while reset is still high must not launch a conversion.
    bus.start = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    bus.start = 1'b0;
    @(posedge clock); #1;
    check("reset_start_busy", 32'(bus.busy), 32'd0);
    ndone = 0;
    for (int k = 0; k < 45; k++) begin
      @(posedge clock); #1;
      if (bus.done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
